// File: rtl/mem_access_pkg.sv
// Shared types and default sizing for the MAR/MDR memory access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} accState_t;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefAddrW   = 9;
  localparam int unsigned DefTimeout = 64;
  localparam int unsigned DefTimerW  = $clog2(DefTimeout);

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter for the access watchdog: clears on request entry, flags expiry at Limit-1.
module wait_timer
  import mem_access_pkg::*;
#(
  parameter int unsigned Width = DefTimerW,
  parameter int unsigned Limit = DefTimeout
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [Width-1:0] countQ;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      countQ <= '0;
    end else if (clear) begin
      countQ <= '0;
    end else if (enable && !expire) begin
      countQ <= countQ + 1'b1;
    end
  end

  assign expire = (countQ == Width'(Limit - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR memory access unit with a request/acknowledge memory port.
// Optional watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [ADDR_W-1:0] mar_q,
  output logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  if (TIMEOUT < 2) begin : gBadTimeout
    $error("mem_access_unit: TIMEOUT must be at least 2");
  end

  accState_t         stateQ, stateD;
  logic [ADDR_W-1:0] marQ;
  logic [DATA_W-1:0] mdrQ;
  logic              weQ;
  logic              inReq;
  logic              cmdOk;
  logic              start;
  logic              expire;

  assign inReq = (stateQ == REQ);
  assign cmdOk = (stateQ == IDLE) || (stateQ == DONE);
  assign start = cmdOk && (Read || Write);

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: if (start) stateD = REQ;
      REQ: begin
        // Ack takes priority over an expiring watchdog in the same cycle.
        if (mem_ack)     stateD = DONE;
        else if (expire) stateD = ERR;
      end
      DONE:    stateD = start ? REQ : IDLE;
      ERR:     stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stateQ <= IDLE;
      marQ   <= '0;
      mdrQ   <= '0;
      weQ    <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (start) weQ <= Write;
      // Address and data registers are frozen while an access is in flight.
      if (MARin && !inReq) marQ <= bus_in[ADDR_W-1:0];
      if (inReq && mem_ack && !weQ) begin
        mdrQ <= mem_rdata;
      end else if (MDRin && !inReq) begin
        mdrQ <= bus_in;
      end
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT);

  logic errQ;

  wait_timer #(
    .Width(TimerW),
    .Limit(TIMEOUT)
  ) uWaitTimer (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (start),
    .enable(inReq && !mem_ack),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      errQ <= 1'b0;
    end else if (start) begin
      errQ <= 1'b0;
    end else if (inReq && !mem_ack && expire) begin
      errQ <= 1'b1;
    end
  end

  assign timeout_err = errQ;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign mar_q     = marQ;
  assign mdr_q     = mdrQ;
  assign busy      = inReq;
  assign done      = (stateQ == DONE);
  assign mem_req   = inReq;
  assign mem_we    = weQ;
  assign mem_addr  = marQ;
  assign mem_wdata = mdrQ;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; inputs change and outputs are sampled on negedge.
module tb_mem_access_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;
  localparam int unsigned TO = 8;

  logic          clk;
  logic          clr_n;
  logic [DW-1:0] bus_in;
  logic          MARin, MDRin, Read, Write;
  logic [AW-1:0] mar_q;
  logic [DW-1:0] mdr_q;
  logic          busy, done, timeout_err, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .bus_in     (bus_in),
    .MARin      (MARin),
    .MDRin      (MDRin),
    .Read       (Read),
    .Write      (Write),
    .mar_q      (mar_q),
    .mdr_q      (mdr_q),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    clr_n = 1'b0; bus_in = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    mem_rdata = '0; mem_ack = 0;
    @(negedge clk);
    tests++; if (mar_q !== 9'h000) begin fails++; $display("FAIL reset_mar: got %h want 000", mar_q); end
    tests++; if (mdr_q !== 32'h0) begin fails++; $display("FAIL reset_mdr: got %h want 0", mdr_q); end
    tests++; if ({busy, done, timeout_err, mem_req, mem_we} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, timeout_err, mem_req, mem_we});
    end
    clr_n = 1'b1;
  endtask

  task automatic test_read();
    @(negedge clk); bus_in = 32'h0000_0012; MARin = 1;
    @(negedge clk); MARin = 0; Read = 1;
    @(negedge clk); Read = 0;
    tests++; if ({mem_req, busy, mem_we} !== 3'b110) begin
      fails++; $display("FAIL read_req: got req/busy/we %b want 110", {mem_req, busy, mem_we});
    end
    tests++; if (mem_addr !== 9'h012) begin fails++; $display("FAIL read_addr: got %h want 012", mem_addr); end
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); mem_ack = 0;
    tests++; if ({done, mem_req} !== 2'b10) begin
      fails++; $display("FAIL read_done: got done/req %b want 10", {done, mem_req});
    end
    tests++; if (mdr_q !== 32'hDEAD_BEEF) begin fails++; $display("FAIL read_mdr: got %h want deadbeef", mdr_q); end
    @(negedge clk);
    tests++; if ({done, busy} !== 2'b00) begin
      fails++; $display("FAIL read_idle: got done/busy %b want 00", {done, busy});
    end
  endtask

  task automatic test_write_wait();
    @(negedge clk); bus_in = 32'h1234_5678; MDRin = 1;
    @(negedge clk); MDRin = 0; bus_in = 32'h0000_01FF; MARin = 1;
    @(negedge clk); MARin = 0; bus_in = '0; Write = 1;
    @(negedge clk); Write = 0;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if ({mem_req, mem_we, done} !== 3'b110 || mem_wdata !== 32'h1234_5678 || mem_addr !== 9'h1FF) begin
        fails++;
        $display("FAIL write_hold[%0d]: got req/we/done %b wdata %h addr %h want 110 12345678 1ff",
                 i, {mem_req, mem_we, done}, mem_wdata, mem_addr);
      end
      if (i == 5) mem_ack = 1;
      @(negedge clk);
    end
    mem_ack = 0;
    tests++; if ({done, mem_req} !== 2'b10) begin
      fails++; $display("FAIL write_done: got done/req %b want 10", {done, mem_req});
    end
  endtask

  task automatic test_rw_collision_hold();
    @(negedge clk); Read = 1; Write = 1;
    @(negedge clk); Read = 0; Write = 0;
    tests++; if ({mem_req, mem_we} !== 2'b11) begin
      fails++; $display("FAIL rw_write_wins: got req/we %b want 11", {mem_req, mem_we});
    end
    bus_in = 32'h0000_0055; MARin = 1; MDRin = 1;
    @(negedge clk);
    tests++; if (mar_q !== 9'h1FF || mdr_q !== 32'h1234_5678) begin
      fails++; $display("FAIL busy_ignore: got mar %h mdr %h want 1ff 12345678", mar_q, mdr_q);
    end
    mem_ack = 1;
    @(negedge clk); mem_ack = 0; MDRin = 0;
    tests++; if (done !== 1'b1 || mar_q !== 9'h1FF) begin
      fails++; $display("FAIL done_mar_hold: got done %b mar %h want 1 1ff", done, mar_q);
    end
    @(negedge clk); MARin = 0;
    tests++; if (mar_q !== 9'h055) begin fails++; $display("FAIL mar_after_done: got %h want 055", mar_q); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); Write = 1;
    @(negedge clk); Write = 0; mem_ack = 1;
    @(negedge clk); mem_ack = 0;
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_wdone: got %b want 1", done); end
    Read = 1;
    @(negedge clk); Read = 0;
    tests++; if ({mem_req, mem_we, done} !== 3'b100) begin
      fails++; $display("FAIL b2b_req: got req/we/done %b want 100", {mem_req, mem_we, done});
    end
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk); mem_ack = 0;
    tests++; if (done !== 1'b1 || mdr_q !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL b2b_rdone: got done %b mdr %h want 1 cafef00d", done, mdr_q);
    end
    @(negedge clk); mem_ack = 1; mem_rdata = 32'h1111_1111;
    @(negedge clk); mem_ack = 0;
    tests++; if ({busy, done, mem_req} !== 3'b000 || mdr_q !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL idle_ack: got busy/done/req %b mdr %h want 000 cafef00d",
                        {busy, done, mem_req}, mdr_q);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk); Read = 1;
    @(negedge clk); Read = 0;
    repeat (3) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    tests++; if ({mem_req, busy} !== 2'b00) begin
      fails++; $display("FAIL async_reset_req: got req/busy %b want 00", {mem_req, busy});
    end
    tests++; if (mar_q !== '0 || mdr_q !== '0 || {done, timeout_err, mem_we} !== 3'b000) begin
      fails++; $display("FAIL async_reset_all: got mar %h mdr %h d/e/we %b want 0",
                        mar_q, mdr_q, {done, timeout_err, mem_we});
    end
    @(negedge clk); clr_n = 1'b1;
    @(negedge clk); Read = 1;
    @(negedge clk); Read = 0;
    tests++; if ({mem_req, mem_addr} !== {1'b1, 9'h000}) begin
      fails++; $display("FAIL post_reset_req: got req %b addr %h want 1 000", mem_req, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk); mem_ack = 0;
    tests++; if (done !== 1'b1 || mdr_q !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL post_reset_read: got done %b mdr %h want 1 0badf00d", done, mdr_q);
    end
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_watchdog();
    int reqCycles;
    reqCycles = 0;
    @(negedge clk); Read = 1;
    @(negedge clk); Read = 0;
    for (int i = 0; i < 20 && mem_req; i++) begin
      reqCycles++;
      @(negedge clk);
    end
    tests++; if (reqCycles != 8) begin fails++; $display("FAIL wd_req_cycles: got %0d want 8", reqCycles); end
    tests++; if ({mem_req, busy, timeout_err} !== 3'b001 || mdr_q !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL wd_abort: got req/busy/err %b mdr %h want 001 0badf00d",
                        {mem_req, busy, timeout_err}, mdr_q);
    end
    @(negedge clk);
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL wd_sticky: got %b want 1", timeout_err); end
    Read = 1;
    @(negedge clk); Read = 0;
    tests++; if ({mem_req, timeout_err} !== 2'b10) begin
      fails++; $display("FAIL wd_clear: got req/err %b want 10", {mem_req, timeout_err});
    end
    // Ack on the eighth request cycle coincides with expiry and must complete normally.
    repeat (7) @(negedge clk);
    mem_ack = 1; mem_rdata = 32'h5A5A_A5A5;
    @(negedge clk); mem_ack = 0;
    tests++; if ({done, timeout_err} !== 2'b10 || mdr_q !== 32'h5A5A_A5A5) begin
      fails++; $display("FAIL wd_ack_wins: got done/err %b mdr %h want 10 5a5aa5a5",
                        {done, timeout_err}, mdr_q);
    end
  endtask
`else
  task automatic test_no_watchdog();
    @(negedge clk); Read = 1;
    @(negedge clk); Read = 0;
    repeat (12) @(negedge clk);
    tests++; if ({mem_req, timeout_err} !== 2'b10) begin
      fails++; $display("FAIL nowd_wait: got req/err %b want 10", {mem_req, timeout_err});
    end
    mem_ack = 1; mem_rdata = 32'h5A5A_A5A5;
    @(negedge clk); mem_ack = 0;
    tests++; if (done !== 1'b1 || mdr_q !== 32'h5A5A_A5A5) begin
      fails++; $display("FAIL nowd_done: got done %b mdr %h want 1 5a5aa5a5", done, mdr_q);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_rw_collision_hold();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised MAR/MDR memory access unit for the single-bus CPU datapath; replaces the fixed-latency direct RAM hookup with a request/acknowledge memory port. It holds MAR and MDR, and issues one read or write per command with any number of wait states. An optional watchdog aborts accesses that never complete. It sits between the bus/control unit and the memory, and drives the MDR and MAR values back to the bus multiplexer.

## Interface
- DATA_W, 32, data width of bus, MDR and memory data
- ADDR_W, 9, width of MAR and memory address
- TIMEOUT, 64, cycles in REQ without ack before abort (used only with watchdog); must be ≥2
- clk  in  1  clock, rising edge
- clr_n  in  1  asynchronous, active-low reset
- bus_in  in  DATA_W  bus value
- MARin  in  1  load MAR from bus_in[ADDR_W-1:0]
- MDRin  in  1  load MDR from bus_in
- Read  in  1  start read command (single-cycle strobe)
- Write  in  1  start write command (single-cycle strobe)
- mar_q  out  ADDR_W  MAR contents
- mdr_q  out  DATA_W  MDR contents
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  sticky abort flag
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  equals mar_q
- mem_wdata  out  DATA_W  equals mdr_q
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only in REQ

## Operation
- States: IDLE, REQ, DONE, ERR. Reset → IDLE.
- Commands are accepted in IDLE or DONE only.
- Read or Write accepted: latch mem_we (Write=1), clear timeout_err, go to REQ.
- Read and Write in the same cycle: Write wins; Read is dropped.
- REQ: mem_req=1, busy=1. On mem_ack=1:
  - read: MDR ← mem_rdata.
  - write: memory takes mem_wdata.
  - Then go to DONE.
- DONE: done=1 for one cycle, then IDLE. A command in DONE goes directly to REQ.
- ERR (watchdog only): mem_req=0, timeout_err←1, MDR unchanged; next cycle IDLE.
- MARin / MDRin are honoured in IDLE, DONE and ERR. While busy they are ignored, so address and data stay stable during an access.
- Read/Write while busy are ignored (not queued).
- MDRin and a read completing in the same cycle cannot coincide, because MDRin is ignored in REQ.
- mem_ack outside REQ is ignored.

## Timing
- All outputs are registered or decoded from the state register. No combinational path from mem_ack to mem_req.
- Reset values: mar_q=0, mdr_q=0, busy=0, done=0, timeout_err=0, mem_req=0, mem_we=0.
- Reset mid-access drops mem_req immediately (asynchronously).
- Command strobe sampled at edge N → mem_req high in cycle N+1.
- mem_ack high in cycle N+1+k (k wait states) → done and mdr_q valid in cycle N+2+k; mem_req low in that cycle.
- Minimum latency is 2 cycles strobe→done (k=0).
- Back-to-back: a strobe issued during the done cycle gives mem_req again in the next cycle, with no IDLE gap.
- Watchdog: a wait counter clears on REQ entry and increments each REQ cycle without ack. If it reaches TIMEOUT−1 without ack → ERR at the next edge.
- Ack arriving in the same cycle the counter expires: ack wins, the access completes normally.

## Configuration
- MEM_ACCESS_TIMEOUT_EN defined: watchdog, counter and ERR state are present; TIMEOUT applies.
- Not defined: no counter; REQ waits indefinitely; timeout_err tied 0; ERR unreachable; TIMEOUT unused.

## Structure
- Package mem_access_pkg: state enum (IDLE, REQ, DONE, ERR), default DATA_W/ADDR_W/TIMEOUT constants, and the counter width $clog2(TIMEOUT).
- Sub-module wait_timer: clear/enable/expire counter, instantiated only under MEM_ACCESS_TIMEOUT_EN.

## Test plan
- Reset, then MARin with bus 0x0000_0012, then Read; memory acks on the first REQ cycle with 0xDEAD_BEEF → mem_addr=0x012, done 2 cycles after the strobe, mdr_q=0xDEAD_BEEF.
- MDRin with 0x1234_5678, MARin with 0x1FF, Write, ack after 5 wait states → mem_we=1 and mem_wdata=0x1234_5678 held for 6 cycles, done 7 cycles after the strobe.
- Read and Write in the same cycle → write access only. MARin with 0x055 mid-access → mar_q unchanged until done.
- With MEM_ACCESS_TIMEOUT_EN, TIMEOUT=8, no ack → mem_req high 8 cycles, then low, timeout_err=1, mdr_q unchanged. Next Read clears timeout_err.
- clr_n pulsed low during REQ after 3 wait states → mem_req and busy drop immediately; all outputs 0; a subsequent Read works normally.
- Strobe Read during the done cycle of a prior write → mem_req reasserted in the next cycle, no idle gap; mem_ack pulsed while IDLE has no effect.
